// File: rtl/twiddle_sched_pkg.sv
// Shared types and helpers for the twiddle scheduler: FSM state encoding,
// clamped width helpers and the Cooley-Tukey twiddle index formula.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } sched_state_e;

  // clog2 clamped to at least one bit so degenerate sizes still get a port
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  // RAM address width for a table of 'depth' twiddles
  function automatic int aw_of(input int depth);
    return clog2_min1(depth);
  endfunction

  // Stage index width for 'logn' stages
  function automatic int sw_of(input int logn);
    return clog2_min1(logn);
  endfunction

  // Twiddle table index for butterfly j of stage s: keep the low s bits of j
  // and scale them up so the stride halves every stage.
  function automatic int tw_index(input int s, input int j, input int logn);
    return (j & ((1 << s) - 1)) << (logn - 1 - s);
  endfunction

endpackage

// File: rtl/twiddle_sched_addr_gen.sv
// Stage/butterfly counters for the replay phase. Produces the twiddle read
// address from the registered counters and flags the final butterfly.
module twiddle_addr_gen
  import ntt_pkg::*;
#(
  parameter int N = 8,
  localparam int DEPTH = N / 2,
  localparam int LOGN = $clog2(N),
  localparam int AW = aw_of(DEPTH),
  localparam int SW = sw_of(LOGN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [SW-1:0] stage,
  output logic [AW-1:0] bfly,
  output logic          last,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] J_MAX = AW'(DEPTH - 1);
  localparam logic [SW-1:0] S_MAX = SW'(LOGN - 1);

  // Last-butterfly flag and read address, purely from the counters
  always_comb begin
    last = (stage == S_MAX) && (bfly == J_MAX);
    addr = AW'(tw_index(int'(stage), int'(bfly), LOGN));
  end

  // Walk j within a stage, then step s; wrap both after the final butterfly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
      bfly  <= '0;
    end else if (clr) begin
      stage <= '0;
      bfly  <= '0;
    end else if (adv) begin
      if (last) begin
        stage <= '0;
        bfly  <= '0;
      end else if (bfly == J_MAX) begin
        bfly  <= '0;
        stage <= stage + 1'b1;
      end else begin
        bfly <= bfly + 1'b1;
      end
    end
  end

endmodule

// File: rtl/twiddle_sched.sv
// Twiddle RAM controller: loads N/2 twiddles from a stream into sequential
// RAM addresses, then replays them stage by stage in Cooley-Tukey order.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holding valid keeps its data stable until the
// transfer; ready may change freely and never depends on valid here.
module twiddle_sched
  import ntt_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8,
  localparam int DEPTH = N / 2,
  localparam int LOGN = $clog2(N),
  localparam int AW = aw_of(DEPTH),
  localparam int SW = sw_of(LOGN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  output logic          ram_write_en,
  output logic [AW-1:0] ram_write_addr,
  output logic [W-1:0]  ram_write_data,
  output logic [AW-1:0] ram_read_addr,
  input  logic [W-1:0]  ram_read_data,
  input  logic          ram_full,
  input  logic          start,
  output logic          tw_valid,
  input  logic          tw_ready,
  output logic [W-1:0]  tw_data,
  output logic [SW-1:0] tw_stage,
  output logic [AW-1:0] tw_bfly,
  output logic          tw_last,
  output logic          loaded,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [AW-1:0] WR_MAX = AW'(DEPTH - 1);

  sched_state_e  state;
  logic [AW-1:0] wr_cnt;
  logic          adv;
  logic          clr;
  logic          last_raw;

  // A run begins only from READY with a complete table; a reload request wins
  assign clr = (state == READY) && start && loaded && !load_start;
  assign adv = tw_valid && tw_ready;

  // Load path drives the RAM write port directly from the stream
  assign ram_write_en   = load_valid && load_ready;
  assign ram_write_addr = wr_cnt;
  assign ram_write_data = load_data;

  // Replay data comes straight from the asynchronous-read RAM
  assign tw_data   = ram_read_data;
  assign tw_last   = tw_valid && last_raw;
  assign dbg_state = state;

  twiddle_addr_gen #(
    .N(N)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .adv  (adv),
    .stage(tw_stage),
    .bfly (tw_bfly),
    .last (last_raw),
    .addr (ram_read_addr)
  );

  // Scheduler FSM with registered status and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      load_ready <= 1'b0;
      tw_valid   <= 1'b0;
      loaded     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (ram_write_en) begin
            if (wr_cnt == WR_MAX) begin
              state      <= READY;
              load_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        READY: begin
          if (load_start) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
            loaded     <= 1'b0;
          end else begin
            loaded <= ram_full;
            if (start && loaded) begin
              state    <= RUN;
              tw_valid <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        RUN: begin
          loaded <= ram_full;
          if (adv && last_raw) begin
            state    <= READY;
            tw_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_sched.sv
// Directed bench for twiddle_sched: N=8 load/replay/backpressure/illegal
// requests/mid-run reset, plus an N=2 instance for the single-twiddle case.
module tb_twiddle_sched;
  import ntt_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- N=8 instance ----------------
  logic          load_start, load_valid, load_ready;
  logic [W-1:0]  load_data;
  logic          ram_write_en;
  logic [1:0]    ram_write_addr;
  logic [W-1:0]  ram_write_data;
  logic [1:0]    ram_read_addr;
  logic [W-1:0]  ram_read_data;
  logic          ram_full;
  logic          start, tw_valid, tw_ready;
  logic [W-1:0]  tw_data;
  logic [1:0]    tw_stage;
  logic [1:0]    tw_bfly;
  logic          tw_last, loaded, busy, done;
  logic [1:0]    dbg_state;

  twiddle_sched #(.W(W), .N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .ram_full(ram_full),
    .start(start), .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_data(tw_data),
    .tw_stage(tw_stage), .tw_bfly(tw_bfly), .tw_last(tw_last),
    .loaded(loaded), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- N=2 instance ----------------
  logic          load_start2, load_valid2, load_ready2;
  logic [W-1:0]  load_data2;
  logic          ram_write_en2;
  logic [0:0]    ram_write_addr2;
  logic [W-1:0]  ram_write_data2;
  logic [0:0]    ram_read_addr2;
  logic [W-1:0]  ram_read_data2;
  logic          ram_full2;
  logic          start2, tw_valid2, tw_ready2;
  logic [W-1:0]  tw_data2;
  logic [0:0]    tw_stage2;
  logic [0:0]    tw_bfly2;
  logic          tw_last2, loaded2, busy2, done2;
  logic [1:0]    dbg_state2;

  twiddle_sched #(.W(W), .N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start2), .load_valid(load_valid2), .load_ready(load_ready2),
    .load_data(load_data2),
    .ram_write_en(ram_write_en2), .ram_write_addr(ram_write_addr2),
    .ram_write_data(ram_write_data2), .ram_read_addr(ram_read_addr2),
    .ram_read_data(ram_read_data2), .ram_full(ram_full2),
    .start(start2), .tw_valid(tw_valid2), .tw_ready(tw_ready2), .tw_data(tw_data2),
    .tw_stage(tw_stage2), .tw_bfly(tw_bfly2), .tw_last(tw_last2),
    .loaded(loaded2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- RAM models ----------------
  logic         ram_clr;
  logic         full_block;
  logic [W-1:0] ram8 [4];
  logic [3:0]   written8;
  logic [W-1:0] ram2_word;
  logic         written2;

  always @(posedge clk) begin
    if (ram_clr) begin
      written8 <= '0;
      written2 <= 1'b0;
    end else begin
      if (ram_write_en) begin
        ram8[ram_write_addr]     <= ram_write_data;
        written8[ram_write_addr] <= 1'b1;
      end
      if (ram_write_en2) begin
        ram2_word <= ram_write_data2;
        written2  <= 1'b1;
      end
    end
  end

  assign ram_read_data  = ram8[ram_read_addr];
  assign ram_full       = (&written8) & ~full_block;
  assign ram_read_data2 = ram2_word;
  assign ram_full2      = written2;

  // ---------------- vector tables ----------------
  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         we;
    logic [1:0]   addr;
  } load_vec_t;

  typedef struct {
    logic         ready;
    logic [1:0]   addr;
    logic [W-1:0] data;
    logic [1:0]   stage;
    logic [1:0]   bfly;
    logic         last;
  } run_vec_t;

  load_vec_t    load_tab [7];
  run_vec_t     run_tab  [15];
  logic [W-1:0] run_data [12];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got 0x%0h, expected nothing (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_load_ready"}, 64'(load_ready), 0);
    check({tag, "_ram_write_en"}, 64'(ram_write_en), 0);
    check({tag, "_tw_valid"}, 64'(tw_valid), 0);
    check({tag, "_tw_last"}, 64'(tw_last), 0);
    check({tag, "_loaded"}, 64'(loaded), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_ram_read_addr"}, 64'(ram_read_addr), 0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // Streams the load table; the caller has already requested LOAD
  task automatic load_rows(input string tag);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      load_start = 1'b0;
      start      = 1'b0;
      load_valid = load_tab[i].valid;
      load_data  = load_tab[i].data;
      #1;
      check($sformatf("%s%0d_state", tag, i), 64'(dbg_state), 64'(LOAD));
      check($sformatf("%s%0d_load_ready", tag, i), 64'(load_ready), 1);
      check($sformatf("%s%0d_we", tag, i), 64'(ram_write_en), 64'(load_tab[i].we));
      if (load_tab[i].we) begin
        check($sformatf("%s%0d_waddr", tag, i), 64'(ram_write_addr), 64'(load_tab[i].addr));
        check($sformatf("%s%0d_wdata", tag, i), 64'(ram_write_data), 64'(load_tab[i].data));
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    check({tag, "_end_state"}, 64'(dbg_state), 64'(READY));
    check({tag, "_end_load_ready"}, 64'(load_ready), 0);
    check({tag, "_end_busy"}, 64'(busy), 0);
  endtask

  task automatic run_replay(input string tag, input bit with_stalls, input int inject_row);
    for (int k = 0; k < 12; k++) exp_q.push_back(run_data[k]);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (!with_stalls && !run_tab[i].ready) continue;
      @(negedge clk);
      start      = 1'b0;
      tw_ready   = run_tab[i].ready;
      load_start = (i == inject_row);
      #1;
      check($sformatf("%s%0d_valid", tag, i), 64'(tw_valid), 1);
      check($sformatf("%s%0d_busy", tag, i), 64'(busy), 1);
      check($sformatf("%s%0d_addr", tag, i), 64'(ram_read_addr), 64'(run_tab[i].addr));
      check($sformatf("%s%0d_data", tag, i), 64'(tw_data), 64'(run_tab[i].data));
      check($sformatf("%s%0d_stage", tag, i), 64'(tw_stage), 64'(run_tab[i].stage));
      check($sformatf("%s%0d_bfly", tag, i), 64'(tw_bfly), 64'(run_tab[i].bfly));
      check($sformatf("%s%0d_last", tag, i), 64'(tw_last), 64'(run_tab[i].last));
      if (tw_ready) sb_pop($sformatf("%s%0d_sb", tag, i), tw_data);
    end
    @(negedge clk);
    tw_ready   = 1'b0;
    load_start = 1'b0;
    #1;
    check({tag, "_done"}, 64'(done), 1);
    check({tag, "_end_valid"}, 64'(tw_valid), 0);
    check({tag, "_end_state"}, 64'(dbg_state), 64'(READY));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 0);
    @(negedge clk);
    #1;
    check({tag, "_done_drop"}, 64'(done), 0);
    check({tag, "_loaded"}, 64'(loaded), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;

    load_tab[0] = '{1'b0, 32'h00, 1'b0, 2'd0};
    load_tab[1] = '{1'b1, 32'h11, 1'b1, 2'd0};
    load_tab[2] = '{1'b0, 32'h99, 1'b0, 2'd0};
    load_tab[3] = '{1'b1, 32'h22, 1'b1, 2'd1};
    load_tab[4] = '{1'b1, 32'h33, 1'b1, 2'd2};
    load_tab[5] = '{1'b0, 32'h77, 1'b0, 2'd0};
    load_tab[6] = '{1'b1, 32'h44, 1'b1, 2'd3};

    run_tab[0]  = '{1'b1, 2'd0, 32'h11, 2'd0, 2'd0, 1'b0};
    run_tab[1]  = '{1'b1, 2'd0, 32'h11, 2'd0, 2'd1, 1'b0};
    run_tab[2]  = '{1'b1, 2'd0, 32'h11, 2'd0, 2'd2, 1'b0};
    run_tab[3]  = '{1'b1, 2'd0, 32'h11, 2'd0, 2'd3, 1'b0};
    run_tab[4]  = '{1'b1, 2'd0, 32'h11, 2'd1, 2'd0, 1'b0};
    run_tab[5]  = '{1'b0, 2'd2, 32'h33, 2'd1, 2'd1, 1'b0};
    run_tab[6]  = '{1'b0, 2'd2, 32'h33, 2'd1, 2'd1, 1'b0};
    run_tab[7]  = '{1'b0, 2'd2, 32'h33, 2'd1, 2'd1, 1'b0};
    run_tab[8]  = '{1'b1, 2'd2, 32'h33, 2'd1, 2'd1, 1'b0};
    run_tab[9]  = '{1'b1, 2'd0, 32'h11, 2'd1, 2'd2, 1'b0};
    run_tab[10] = '{1'b1, 2'd2, 32'h33, 2'd1, 2'd3, 1'b0};
    run_tab[11] = '{1'b1, 2'd0, 32'h11, 2'd2, 2'd0, 1'b0};
    run_tab[12] = '{1'b1, 2'd1, 32'h22, 2'd2, 2'd1, 1'b0};
    run_tab[13] = '{1'b1, 2'd2, 32'h33, 2'd2, 2'd2, 1'b0};
    run_tab[14] = '{1'b1, 2'd3, 32'h44, 2'd2, 2'd3, 1'b1};

    run_data[0] = 32'h11; run_data[1]  = 32'h11; run_data[2]  = 32'h11;
    run_data[3] = 32'h11; run_data[4]  = 32'h11; run_data[5]  = 32'h33;
    run_data[6] = 32'h11; run_data[7]  = 32'h33; run_data[8]  = 32'h11;
    run_data[9] = 32'h22; run_data[10] = 32'h33; run_data[11] = 32'h44;

    rst_n       = 1'b0;
    ram_clr     = 1'b1;
    full_block  = 1'b0;
    load_start  = 1'b0; load_valid  = 1'b0; load_data  = '0;
    start       = 1'b0; tw_ready    = 1'b0;
    load_start2 = 1'b0; load_valid2 = 1'b0; load_data2 = '0;
    start2      = 1'b0; tw_ready2   = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    ram_clr = 1'b0;

    // start in IDLE is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_start_valid", 64'(tw_valid), 0);
    check("idle_start_state", 64'(dbg_state), 64'(IDLE));

    // Load with the RAM full flag held low, then start must be ignored
    full_block = 1'b1;
    @(negedge clk);
    load_start = 1'b1;
    load_rows("load1_");
    @(negedge clk);
    #1;
    check("nofull_loaded", 64'(loaded), 0);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    full_block = 1'b0;
    #1;
    check("nofull_start_valid", 64'(tw_valid), 0);
    check("nofull_start_state", 64'(dbg_state), 64'(READY));
    @(negedge clk);
    #1;
    check("full_loaded", 64'(loaded), 1);

    // Replay with tw_ready held high
    run_replay("runA_", 1'b0, -1);

    // Replay with backpressure at s=1 j=1 and a reload request mid-run
    run_replay("runB_", 1'b1, 9);

    // start and load_start together in READY: reload wins
    @(negedge clk);
    start      = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    load_start = 1'b0;
    #1;
    check("both_state", 64'(dbg_state), 64'(LOAD));
    check("both_valid", 64'(tw_valid), 0);
    check("both_loaded", 64'(loaded), 0);
    load_rows("load2_");
    @(negedge clk);
    #1;
    check("reload_loaded", 64'(loaded), 1);

    // Reset while the sixth output is presented
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start    = 1'b0;
      tw_ready = 1'b1;
    end
    @(negedge clk);
    tw_ready = 1'b0;
    #1;
    check("midrun_addr", 64'(ram_read_addr), 2);
    check("midrun_data", 64'(tw_data), 32'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("post_reset_valid", 64'(tw_valid), 0);
    check("post_reset_loaded", 64'(loaded), 0);
    check("post_reset_state", 64'(dbg_state), 64'(IDLE));

    // N=2: one twiddle, one stage, one butterfly
    @(negedge clk);
    load_start2 = 1'b1;
    @(negedge clk);
    load_start2 = 1'b0;
    load_valid2 = 1'b1;
    load_data2  = 32'h5A;
    #1;
    check("n2_load_ready", 64'(load_ready2), 1);
    check("n2_we", 64'(ram_write_en2), 1);
    check("n2_waddr", 64'(ram_write_addr2), 0);
    @(negedge clk);
    load_valid2 = 1'b0;
    #1;
    check("n2_ready_state", 64'(dbg_state2), 64'(READY));
    @(negedge clk);
    #1;
    check("n2_loaded", 64'(loaded2), 1);
    start2 = 1'b1;
    @(negedge clk);
    start2    = 1'b0;
    tw_ready2 = 1'b1;
    #1;
    check("n2_valid", 64'(tw_valid2), 1);
    check("n2_last", 64'(tw_last2), 1);
    check("n2_raddr", 64'(ram_read_addr2), 0);
    check("n2_data", 64'(tw_data2), 32'h5A);
    check("n2_stage", 64'(tw_stage2), 0);
    check("n2_bfly", 64'(tw_bfly2), 0);
    @(negedge clk);
    tw_ready2 = 1'b0;
    #1;
    check("n2_done", 64'(done2), 1);
    check("n2_end_valid", 64'(tw_valid2), 0);
    check("n2_end_busy", 64'(busy2), 0);
    check("n2_end_state", 64'(dbg_state2), 64'(READY));
    @(negedge clk);
    #1;
    check("n2_done_drop", 64'(done2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
